writeback_queue: RTL

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/wb_pkg.sv | 11 +
 rtl/wb_if.sv | 35 +++
 rtl/wb_match.sv | 27 ++
 rtl/writeback_queue.sv | 118 +++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared widths, default depth and entry type for the writeback queue.
package wb_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_if.sv
// Bus bundle between execute stage, writeback queue, register file and decode forwarding.
interface wb_if #(
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int DATA_W = wb_pkg::DATA_W
);
  // Handshakes: a result transfers on a rising edge with in_valid && in_ready;
  // a write retires on a rising edge with wr_en && wr_ack. Once wr_en is high,
  // wr_addr/wr_data hold steady until wr_ack is seen.
  logic              in_valid;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] fwd_rs;
  logic [ADDR_W-1:0] fwd_rt;
  logic              fwd_rs_hit;
  logic              fwd_rt_hit;
  logic [DATA_W-1:0] fwd_rs_data;
  logic [DATA_W-1:0] fwd_rt_data;

  modport master (
    output in_valid, in_rd, in_data, wr_ack, fwd_rs, fwd_rt,
    input  in_ready, wr_en, wr_addr, wr_data,
           fwd_rs_hit, fwd_rt_hit, fwd_rs_data, fwd_rt_data
  );

  modport slave (
    input  in_valid, in_rd, in_data, wr_ack, fwd_rs, fwd_rt,
    output in_ready, wr_en, wr_addr, wr_data,
           fwd_rs_hit, fwd_rt_hit, fwd_rs_data, fwd_rt_data
  );
endinterface

// File: rtl/wb_match.sv
// Youngest-match search over queue entries presented oldest-first (index 0 = oldest).
module wb_match #(
  parameter int N      = wb_pkg::DEPTH,
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int DATA_W = wb_pkg::DATA_W
) (
  input  logic [ADDR_W-1:0]         addr,
  input  logic [N-1:0]              valid,
  input  logic [N-1:0][ADDR_W-1:0]  rd,
  input  logic [N-1:0][DATA_W-1:0]  data,
  output logic                      hit,
  output logic [DATA_W-1:0]         hit_data
);
  // Later indices overwrite earlier ones, so the youngest match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    if (addr != '0) begin
      for (int i = 0; i < N; i++) begin
        if (valid[i] && (rd[i] == addr)) begin
          hit      = 1'b1;
          hit_data = data[i];
        end
      end
    end
  end
endmodule

// File: rtl/writeback_queue.sv
// FIFO of pending register-file writes with optional decode forwarding.
// Define WB_FORWARD_EN to build the forwarding compare path.
module writeback_queue #(
  parameter int DEPTH  = wb_pkg::DEPTH,
  parameter int DATA_W = wb_pkg::DATA_W,
  parameter int ADDR_W = wb_pkg::ADDR_W
) (
  input logic clk,
  input logic rst,
  wb_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
  logic [ADDR_W-1:0] rd_mem_d   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_d [DEPTH];
  logic full, empty, push, pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Writes to r0 are accepted but dropped so they never occupy a slot.
  assign push = bus.in_valid && !full && (bus.in_rd != '0);
  assign pop  = !empty && bus.wr_ack;

  assign bus.in_ready = !full;
  assign bus.wr_en    = !empty;
  assign bus.wr_addr  = empty ? '0 : rd_mem_q[rd_ptr_q];
  assign bus.wr_data  = empty ? '0 : data_mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      rd_mem_d[wr_ptr_q]   = bus.in_rd;
      data_mem_d[wr_ptr_q] = bus.in_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is qualified by count_q, so it needs no reset.
  always_ff @(posedge clk) begin
    rd_mem_q   <= rd_mem_d;
    data_mem_q <= data_mem_d;
  end

`ifdef WB_FORWARD_EN
  logic [DEPTH-1:0]             age_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] age_rd;
  logic [DEPTH-1:0][DATA_W-1:0] age_data;

  // Rotate storage into age order so the matcher only needs a linear scan.
  always_comb begin
    age_valid = '0;
    age_rd    = '0;
    age_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age_valid[i] = (CNT_W'(i) < count_q);
      age_rd[i]    = rd_mem_q[rd_ptr_q + PTR_W'(i)];
      age_data[i]  = data_mem_q[rd_ptr_q + PTR_W'(i)];
    end
  end

  wb_match #(.N(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match_rs (
    .addr     (bus.fwd_rs),
    .valid    (age_valid),
    .rd       (age_rd),
    .data     (age_data),
    .hit      (bus.fwd_rs_hit),
    .hit_data (bus.fwd_rs_data)
  );

  wb_match #(.N(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match_rt (
    .addr     (bus.fwd_rt),
    .valid    (age_valid),
    .rd       (age_rd),
    .data     (age_data),
    .hit      (bus.fwd_rt_hit),
    .hit_data (bus.fwd_rt_data)
  );
`else
  logic unused_fwd;
  assign unused_fwd      = ^{bus.fwd_rs, bus.fwd_rt};
  assign bus.fwd_rs_hit  = 1'b0;
  assign bus.fwd_rt_hit  = 1'b0;
  assign bus.fwd_rs_data = '0;
  assign bus.fwd_rt_data = '0;
`endif
endmodule
